// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared NES bus constants and sprite DMA state encoding
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    STATE_IDLE  = 3'd0,
    STATE_HALT  = 3'd1,
    STATE_ALIGN = 3'd2,
    STATE_READ  = 3'd3,
    STATE_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - NES sprite DMA controller and CPU bus arbiter
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDRESS  = DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDRESS = OAM_DATA_ADDR,
  parameter int          BYTE_COUNT       = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_cpu_halt,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(BYTE_COUNT - 1);

  dma_state_t r_state;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_data;
  logic       r_cycle_odd;
  logic       r_active;

  // State advances on the falling edge so the DMA stays in step with the CPU core.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= STATE_IDLE;
      r_page      <= 8'h00;
      r_index     <= 8'h00;
      r_data      <= 8'h00;
      r_cycle_odd <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_cycle_odd <= ~r_cycle_odd;
      case (r_state)
        STATE_IDLE: begin
          if (!i_cpu_rw && i_cpu_address == DMA_REG_ADDRESS) begin
            r_page   <= i_cpu_data;
            r_state  <= STATE_HALT;
            r_active <= 1'b1;
          end
        end
        STATE_HALT: begin
          // An odd halt cycle needs one more dummy read so reads land on even cycles.
          r_state <= r_cycle_odd ? STATE_ALIGN : STATE_READ;
        end
        STATE_ALIGN: begin
          r_state <= STATE_READ;
        end
        STATE_READ: begin
          r_data  <= i_bus_data;
          r_state <= STATE_WRITE;
        end
        STATE_WRITE: begin
          if (r_index == LAST_INDEX) begin
            r_index  <= 8'h00;
            r_state  <= STATE_IDLE;
            r_active <= 1'b0;
          end else begin
            r_index <= r_index + 8'd1;
            r_state <= STATE_READ;
          end
        end
        default: begin
          r_state  <= STATE_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_halt   = r_active;
  assign o_dma_active = r_active;

  always_comb begin
    o_rw      = i_cpu_rw;
    o_address = i_cpu_address;
    o_data    = i_cpu_data;
    if (r_active) begin
      o_data = r_data;
      case (r_state)
        STATE_READ: begin
          o_rw      = 1'b1;
          o_address = {r_page, r_index};
        end
        STATE_WRITE: begin
          o_rw      = 1'b0;
          o_address = OAM_DATA_ADDRESS;
        end
        default: begin
          o_rw      = 1'b1;
          o_address = i_cpu_address;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_data;
  logic        halt;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        active;
  logic        par;

  int n_checks = 0;
  int n_pass   = 0;

  oam_dma dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_cpu_rw      (cpu_rw),
    .i_cpu_address (cpu_addr),
    .i_cpu_data    (cpu_data),
    .i_bus_data    (bus_data),
    .o_cpu_halt    (halt),
    .o_rw          (rw),
    .o_address     (addr),
    .o_data        (data),
    .o_dma_active  (active)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Model RAM: every location holds its low address byte xor A5.
  assign bus_data = addr[7:0] ^ 8'hA5;

  // Cycle parity model, as seen during the current cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= ~par;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic [7:0] d);
    cpu_rw   = r;
    cpu_addr = a;
    cpu_data = d;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Trigger a transfer from the page and check every bus cycle up to bus hand-back.
  task automatic run_transfer(input logic [7:0] page, input int want_len);
    logic       need_par;
    int         tries;
    int         dummies;
    int         k;
    logic [7:0] idx;
    logic [18:0] exp_v;
    need_par = (want_len == 513);
    tries = 0;
    next_cycle();
    while (par != need_par && tries < 3) begin
      drive(1'b1, 16'h8000, 8'h00);
      next_cycle();
      tries++;
    end
    drive(1'b0, 16'h4014, page);
    sample();
    chk("trigger_cycle_passthru", {halt, rw, addr, data}, {1'b0, 1'b0, 16'h4014, page});
    next_cycle();
    drive(1'b1, 16'hC123, 8'hEE);
    dummies = want_len - 512;
    for (int n = 0; n <= want_len; n++) begin
      if (n > 0) next_cycle();
      sample();
      if (n == want_len) begin
        chk("handback", {halt, active, rw, addr, data}, {1'b0, 1'b0, 1'b1, 16'hC123, 8'hEE});
      end else if (n < dummies) begin
        chk("dummy_read", {halt, active, rw, addr}, {1'b1, 1'b1, 1'b1, 16'hC123});
      end else begin
        k   = n - dummies;
        idx = 8'(k / 2);
        if (k % 2 == 0) begin
          exp_v = {1'b1, 1'b1, 1'b1, page, idx};
          chk("dma_read", {halt, active, rw, addr}, exp_v);
        end else begin
          exp_v = {1'b1, 1'b1, 1'b0, 16'h2004};
          chk("dma_write", {halt, active, rw, addr}, exp_v);
          chk("dma_write_data", data, idx ^ 8'hA5);
        end
      end
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_halt;
    logic        exp_rw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int writes;
    int bad;
    int guard;

    vecs[0] = '{1'b1, 16'h8000, 8'h00, 1'b0, 1'b1, 16'h8000, 8'h00};
    vecs[1] = '{1'b0, 16'h0200, 8'h55, 1'b0, 1'b0, 16'h0200, 8'h55};
    vecs[2] = '{1'b0, 16'h4013, 8'h12, 1'b0, 1'b0, 16'h4013, 8'h12};
    vecs[3] = '{1'b0, 16'h4015, 8'h34, 1'b0, 1'b0, 16'h4015, 8'h34};
    vecs[4] = '{1'b1, 16'h4014, 8'h56, 1'b0, 1'b1, 16'h4014, 8'h56};
    vecs[5] = '{1'b1, 16'h8001, 8'h9A, 1'b0, 1'b1, 16'h8001, 8'h9A};
    vecs[6] = '{1'b0, 16'h0300, 8'h77, 1'b0, 1'b0, 16'h0300, 8'h77};

    rst_n = 1'b0;
    drive(1'b1, 16'h1234, 8'h3C);
    repeat (3) @(negedge clk);
    sample();
    chk("reset_state", {halt, active, rw, addr, data}, {1'b0, 1'b0, 1'b1, 16'h1234, 8'h3C});
    next_cycle();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      next_cycle();
      drive(vecs[i].rw, vecs[i].addr, vecs[i].data);
      sample();
      chk($sformatf("vec%0d", i), {halt, rw, addr, data},
          {vecs[i].exp_halt, vecs[i].exp_rw, vecs[i].exp_addr, vecs[i].exp_data});
    end

    run_transfer(8'h02, 513);
    run_transfer(8'h02, 514);
    run_transfer(8'hFF, 514);

    // Reset in the middle of a transfer, right after the 100th OAM write.
    next_cycle();
    drive(1'b0, 16'h4014, 8'h03);
    next_cycle();
    drive(1'b1, 16'hC123, 8'hEE);
    writes = 0;
    guard  = 0;
    while (writes < 100 && guard < 600) begin
      sample();
      if (halt && !rw && addr == 16'h2004) writes++;
      next_cycle();
      guard++;
    end
    chk("mid_reset_reached_byte100", writes, 100);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_passthru", {halt, active, rw, addr, data}, {1'b0, 1'b0, 1'b1, 16'hC123, 8'hEE});
    next_cycle();
    rst_n = 1'b1;
    drive(1'b1, 16'h8000, 8'h00);
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      sample();
      if (halt || active || (!rw && addr == 16'h2004)) bad++;
      next_cycle();
    end
    chk("no_activity_after_reset", bad, 0);

    run_transfer(8'h02, 514);
    run_transfer(8'h02, 513);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
